// File: rtl/operand_fetch_if.sv
// Request/operand handshake between a fetch requester and operand_fetch.
// The requester (master) issues register selects and consumes the operand
// pair; operand_fetch (slave) accepts requests and presents operands.
interface operand_fetch_if #(
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        src_sel;
    logic [1:0]        dst_sel;
    logic              single;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_valid;
    logic              op_ready;

    modport master (
        output req_valid, src_sel, dst_sel, single, op_ready,
        input  req_ready, op_a, op_b, op_valid
    );

    modport slave (
        input  req_valid, src_sel, dst_sel, single, op_ready,
        output req_ready, op_a, op_b, op_valid
    );
endinterface

// File: rtl/operand_fetch.sv
// Read side of the 4x8 register stack. A request is latched in IDLE, operand
// A (src) and optionally operand B (dst) are read one per cycle over a single
// shared read path with same-cycle write forwarding, and the pair is held in
// DONE until the ALU takes it.
module operand_fetch #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_R0,
    input  logic [DATA_W-1:0] in_R1,
    input  logic [DATA_W-1:0] in_R2,
    input  logic [DATA_W-1:0] in_R3,
    input  logic              wr_en,
    input  logic [1:0]        wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    operand_fetch_if.slave    bus,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [1:0]        src_r;
    logic [1:0]        dst_r;
    logic              single_r;
    logic [DATA_W-1:0] op_a_r;
    logic [DATA_W-1:0] op_b_r;
    logic [1:0]        rd_sel_s;
    logic [DATA_W-1:0] rd_data_s;

    // Register read with forwarding: a write landing on the same register in
    // this cycle wins over the stale stack contents.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [1:0]        sel,
        input logic              we,
        input logic [1:0]        wsel,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] r0,
        input logic [DATA_W-1:0] r1,
        input logic [DATA_W-1:0] r2,
        input logic [DATA_W-1:0] r3
    );
        logic [DATA_W-1:0] rd;
        case (sel)
            2'd0:    rd = r0;
            2'd1:    rd = r1;
            2'd2:    rd = r2;
            2'd3:    rd = r3;
            default: rd = r0;
        endcase
        if (we && (wsel == sel)) begin
            return wdata;
        end else begin
            return rd;
        end
    endfunction

    // Shared read path: src select in RD_A (and idle), dst select in RD_B.
    always_comb begin
        rd_sel_s = src_r;
        if (state_r == RD_B) begin
            rd_sel_s = dst_r;
        end else begin
            rd_sel_s = src_r;
        end
        rd_data_s = fwd(rd_sel_s, wr_en, wr_sel, wr_data, in_R0, in_R1, in_R2, in_R3);
    end

    // Next-state decode for the fetch sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    state_s = RD_A;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_A: begin
                if (single_r) begin
                    state_s = DONE;
                end else begin
                    state_s = RD_B;
                end
            end
            RD_B: state_s = DONE;
            DONE: begin
                if (bus.op_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, request latches and operand capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            src_r    <= 2'd0;
            dst_r    <= 2'd0;
            single_r <= 1'b0;
            op_a_r   <= {DATA_W{1'b0}};
            op_b_r   <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        src_r    <= bus.src_sel;
                        dst_r    <= bus.dst_sel;
                        single_r <= bus.single;
                    end
                end
                RD_A: begin
                    op_a_r <= rd_data_s;
                    if (single_r) begin
                        op_b_r <= {DATA_W{1'b0}};
                    end
                end
                RD_B: op_b_r <= rd_data_s;
                default: ;
            endcase
        end
    end

    assign bus.op_a      = op_a_r;
    assign bus.op_b      = op_b_r;
    assign bus.op_valid  = (state_r == DONE);
    assign bus.req_ready = (state_r == IDLE);
    assign busy          = (state_r != IDLE);

endmodule
